c2_bus_master: RTL and testbench

Cache-side initiator for the C2 cache↔memory line bus. Accepts whole-line read and write requests from the cache controller and serialises them onto the shared tristate cmd/data bus in DATA_W-bit beats. For reads it gathers the responder's beats back into a full line. Sits between the cache controller and the memory model, and owns the bus whenever no responder transfer is in progress.

---
 rtl/c2_bus_master_pkg.sv | 37 +++
 rtl/c2_bus_master_if.sv | 28 ++
 rtl/c2_bus_master_serdes.sv | 59 +++++
 rtl/c2_bus_master.sv | 191 +++++++++++++++++++
 tb/tb_c2_bus_master.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/c2_bus_master_pkg.sv
// Shared C2 line-bus types: command encodings, bus geometry constants, master FSM states.
// Latency: none (declarations only).
// Backpressure: n/a.
package c2_bus_pkg;

    localparam int BITS_IN_BYTE    = 8;
    localparam int ADDR2_BUS_SIZE  = 4;
    localparam int DATA2_BUS_SIZE  = 2;
    localparam int CACHE_LINE_SIZE = 16;

    localparam int C2_ADDR_W  = BITS_IN_BYTE * ADDR2_BUS_SIZE;
    localparam int C2_DATA_W  = BITS_IN_BYTE * DATA2_BUS_SIZE;
    localparam int C2_TIMEOUT = 255;

    typedef enum logic [1:0] {
        C2_NOP        = 2'd0,
        C2_RESPONSE   = 2'd1,
        C2_READ_LINE  = 2'd2,
        C2_WRITE_LINE = 2'd3
    } c2_cmd_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_CMD  = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_RD_DATA = 3'd3,
        ST_TURN    = 3'd4,
        ST_WR_DATA = 3'd5,
        ST_WR_GAP  = 3'd6
    } c2_mst_state_t;

    // The master owns cmd/data everywhere except while the responder may be talking.
    function automatic logic c2_master_owns(c2_mst_state_t s);
        return !((s == ST_RD_WAIT) || (s == ST_RD_DATA) || (s == ST_TURN));
    endfunction

endpackage

// File: rtl/c2_bus_master_if.sv
// Cache-controller request/response handshake for the C2 bus master.
// Latency: none (wires only).
// Backpressure: req_ready from the bus master; resp_valid is a pulse with no ready.
interface c2_bus_master_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 128
) ();
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [LINE_W-1:0] req_wdata;
    logic              resp_valid;
    logic [LINE_W-1:0] resp_rdata;
    logic              resp_err;

    // Cache controller side: issues requests, consumes completions.
    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    // Bus master side: accepts requests, reports completions.
    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/c2_bus_master_serdes.sv
// Line<->beat converter: beat counter, write-beat mux, read-beat assembly and completed read line.
// Latency: beat_o follows the counter combinationally; captures and commits land on the next posedge.
// Backpressure: none; the FSM paces every load/capture/increment.
module c2_line_serdes #(
    parameter int DATA_W = 16,
    parameter int BEATS  = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load_i,
    input  logic [BEATS*DATA_W-1:0]  line_i,
    input  logic                     cap_i,
    input  logic [DATA_W-1:0]        beat_i,
    input  logic                     inc_i,
    input  logic                     commit_i,
    output logic [DATA_W-1:0]        beat_o,
    output logic                     last_o,
    output logic [BEATS*DATA_W-1:0]  rdata_o
);
    localparam int LINE_W = BEATS * DATA_W;
    localparam int CNT_W  = $clog2(BEATS);

    logic [CNT_W-1:0]  cnt_q;
    logic [LINE_W-1:0] line_q;
    logic [LINE_W-1:0] rdata_q;

    assign last_o  = (cnt_q == CNT_W'(BEATS - 1));
    assign beat_o  = line_q[cnt_q*DATA_W +: DATA_W];
    assign rdata_o = rdata_q;

    // Beat index: restarts from zero explicitly after the last beat rather than wrapping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (inc_i) begin
            cnt_q <= last_o ? '0 : cnt_q + 1'b1;
        end
    end

    // Working line: write data loaded at acceptance, or read beats assembled in place.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            line_q <= '0;
        end else if (load_i) begin
            line_q <= line_i;
        end else if (cap_i) begin
            line_q[cnt_q*DATA_W +: DATA_W] <= beat_i;
        end
    end

    // Completed read line, held until the next successful read finishes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_q <= '0;
        end else if (commit_i) begin
            rdata_q <= line_q;
        end
    end
endmodule

// File: rtl/c2_bus_master.sv
// C2 line-bus initiator: serialises cache line reads/writes into DATA_W beats on a shared tristate bus.
// Latency: write BEATS+1 cycles; read 1+wait+BEATS+1 cycles from acceptance to the resp_valid pulse.
// Backpressure: req_ready only in IDLE; optional read-wait timeout via C2_TIMEOUT_EN.
module c2_bus_master
    import c2_bus_pkg::*;
#(
    parameter int ADDR_W     = C2_ADDR_W,
    parameter int DATA_W     = C2_DATA_W,
    parameter int LINE_BYTES = CACHE_LINE_SIZE,
    parameter int TIMEOUT    = C2_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset,
    c2_bus_master_if.slave    req_if,
    output logic [ADDR_W-1:0] addr_w,
    inout  wire  [DATA_W-1:0] data_w,
    inout  wire  [1:0]        cmd_w
);
    localparam int LINE_W = LINE_BYTES * BITS_IN_BYTE;
    localparam int BEATS  = LINE_W / DATA_W;

    if (BEATS < 2 || BEATS * DATA_W != LINE_W || TIMEOUT < 1) begin : g_bad_cfg
        $error("c2_bus_master: line must split into at least two whole beats and TIMEOUT must be positive");
    end

    c2_mst_state_t     state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              resp_valid_q, resp_valid_d;

    logic              ser_load, ser_cap, ser_inc, ser_commit;
    logic              ser_last;
    logic [DATA_W-1:0] ser_beat;
    logic [LINE_W-1:0] ser_rdata;

    logic              owner;
    logic [1:0]        cmd_drv;
    logic [DATA_W-1:0] data_drv;
    logic              timed_out;

`ifdef C2_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0] to_q, to_d;
    logic            tmo_q, tmo_d;
    logic            resp_err_q;
    assign timed_out = tmo_q;
`else
    assign timed_out = 1'b0;
`endif

    c2_line_serdes #(
        .DATA_W (DATA_W),
        .BEATS  (BEATS)
    ) u_serdes (
        .clk      (clk),
        .reset    (reset),
        .load_i   (ser_load),
        .line_i   (req_if.req_wdata),
        .cap_i    (ser_cap),
        .beat_i   (data_w),
        .inc_i    (ser_inc),
        .commit_i (ser_commit),
        .beat_o   (ser_beat),
        .last_o   (ser_last),
        .rdata_o  (ser_rdata)
    );

    // Next state, serdes strobes and completion pulse.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        resp_valid_d = 1'b0;
        ser_load     = 1'b0;
        ser_cap      = 1'b0;
        ser_inc      = 1'b0;
        ser_commit   = 1'b0;
`ifdef C2_TIMEOUT_EN
        to_d         = '0;
        tmo_d        = tmo_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req_if.req_valid) begin
                    addr_d = req_if.req_addr;
                    if (req_if.req_write) begin
                        ser_load = 1'b1;
                        state_d  = ST_WR_DATA;
                    end else begin
                        state_d  = ST_RD_CMD;
                    end
                end
            end
            ST_RD_CMD: begin
`ifdef C2_TIMEOUT_EN
                tmo_d = 1'b0;
`endif
                state_d = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                // Anything other than a clean RESPONSE (X/Z, stray commands) just keeps us waiting.
                if (cmd_w == C2_RESPONSE) begin
                    state_d = ST_RD_DATA;
                end
`ifdef C2_TIMEOUT_EN
                else if (to_q == TO_W'(TIMEOUT - 1)) begin
                    tmo_d   = 1'b1;
                    state_d = ST_TURN;
                end else begin
                    to_d = to_q + 1'b1;
                end
`endif
            end
            ST_RD_DATA: begin
                ser_cap = 1'b1;
                ser_inc = 1'b1;
                if (ser_last) begin
                    state_d = ST_TURN;
                end
            end
            ST_TURN: begin
                ser_commit   = !timed_out;
                resp_valid_d = 1'b1;
                state_d      = ST_IDLE;
            end
            ST_WR_DATA: begin
                ser_inc = 1'b1;
                if (ser_last) begin
                    state_d = ST_WR_GAP;
                end
            end
            ST_WR_GAP: begin
                resp_valid_d = 1'b1;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, latched line address and completion pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            resp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            resp_valid_q <= resp_valid_d;
        end
    end

`ifdef C2_TIMEOUT_EN
    // Read-wait cycle counter, timeout flag for the current read, and the qualified error bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            to_q       <= '0;
            tmo_q      <= 1'b0;
            resp_err_q <= 1'b0;
        end else begin
            to_q       <= to_d;
            tmo_q      <= tmo_d;
            resp_err_q <= (state_q == ST_TURN) && tmo_q;
        end
    end
    assign req_if.resp_err = resp_err_q;
`else
    assign req_if.resp_err = 1'b0;
`endif

    // Bus drive values: NOP/zero whenever we own the bus but are not mid-burst.
    always_comb begin
        owner    = c2_master_owns(state_q);
        cmd_drv  = C2_NOP;
        data_drv = '0;
        if (state_q == ST_RD_CMD) begin
            cmd_drv = C2_READ_LINE;
        end else if (state_q == ST_WR_DATA) begin
            cmd_drv  = C2_WRITE_LINE;
            data_drv = ser_beat;
        end
    end

    assign cmd_w  = owner ? cmd_drv  : 2'bz;
    assign data_w = owner ? data_drv : {DATA_W{1'bz}};
    assign addr_w = addr_q;

    assign req_if.req_ready  = (state_q == ST_IDLE);
    assign req_if.resp_valid = resp_valid_q;
    assign req_if.resp_rdata = ser_rdata;
endmodule

// File: tb/tb_c2_bus_master.sv
// Randomised scoreboard bench for c2_bus_master with a line-memory responder on the tristate bus.
// Latency: expectations derived from the command/beat timing of the C2 bus.
// Backpressure: driver holds req_valid until req_ready; responder delay chosen per read.
module tb_c2_bus_master;
    import c2_bus_pkg::*;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 16;
    localparam int LINE_BYTES = 16;
    localparam int LINE_W = 128;
    localparam int BEATS = 8;
    localparam int TMO = 10;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    c2_bus_master_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bif ();
    logic [ADDR_W-1:0] addr_w;
    wire  [DATA_W-1:0] data_w;
    wire  [1:0]        cmd_w;

    logic              tb_drv = 1'b0;
    logic [1:0]        tb_cmd = 2'd0;
    logic [DATA_W-1:0] tb_dat = '0;
    assign cmd_w  = tb_drv ? tb_cmd : 2'bz;
    assign data_w = tb_drv ? tb_dat : {DATA_W{1'bz}};

    c2_bus_master #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINE_BYTES(LINE_BYTES), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .reset(reset), .req_if(bif), .addr_w(addr_w), .data_w(data_w), .cmd_w(cmd_w)
    );

    typedef struct {
        bit          rd;
        logic [127:0] rdata;
        bit          err;
        int          lat;
        int          acc;
    } exp_t;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    exp_t exp_q[$];
    int dly_q[$];
    logic [127:0] wr_exp_line[$];
    int wr_exp_addr[$];
    int resp_edges[$];
    logic [127:0] ref_mem [8];
    logic [127:0] bus_mem [8];
    logic [127:0] last_rd = '0;
    int last_acc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Present one request and hold it until accepted; record the expected completion.
    task automatic issue(input bit wr, input int a, input logic [127:0] line, input int dly, input bit track);
        exp_t e;
        bit acc;
        bif.req_valid = 1'b1;
        bif.req_write = wr;
        bif.req_addr  = ADDR_W'(a);
        bif.req_wdata = line;
        acc = 1'b0;
        for (int i = 0; i < 400 && !acc; i++) begin
            @(negedge clk);
            if (bif.req_ready) begin
                acc = 1'b1;
                if (track) begin
                    e.acc = cyc + 1;
                    e.rd  = !wr;
                    e.err = 1'b0;
                    if (wr) begin
                        ref_mem[a] = line;
                        e.lat   = BEATS + 1;
                        e.rdata = last_rd;
                        wr_exp_line.push_back(line);
                        wr_exp_addr.push_back(a);
                    end else if (dly < 0) begin
                        e.lat   = 1 + TMO + 1;
                        e.err   = 1'b1;
                        e.rdata = last_rd;
                        dly_q.push_back(dly);
                    end else begin
                        e.lat   = 1 + (dly + 1) + BEATS + 1;
                        e.rdata = ref_mem[a];
                        last_rd = ref_mem[a];
                        dly_q.push_back(dly);
                    end
                    exp_q.push_back(e);
                    last_acc = e.acc;
                end
            end
            @(posedge clk);
            #1;
        end
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL req_accept: got never-ready expected ready within 400 cycles");
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending responses expected 0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    // Completion monitor: every resp_valid pulse is matched against the oldest expectation.
    exp_t mon_e;
    always @(negedge clk) begin
        if (reset && bif.resp_valid) begin
            resp_edges.push_back(cyc);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_resp: got resp_valid expected none (cycle %0d)", cyc);
            end else begin
                mon_e = exp_q.pop_front();
                check("resp_latency", 128'(cyc - mon_e.acc), 128'(mon_e.lat));
                check("resp_err", 128'(bif.resp_err), 128'(mon_e.err));
                check("resp_rdata", bif.resp_rdata, mon_e.rdata);
                check("bus_nop_at_resp", 128'(cmd_w), 128'(C2_NOP));
            end
        end
    end

    // Bus monitor: reassembles WRITE bursts, counts READ command cycles, watches for contention.
    int wcnt = 0;
    int rcnt = 0;
    int waddr = 0;
    logic [127:0] wline = '0;
    always @(negedge clk) begin
        if (!reset) begin
            wcnt = 0;
            rcnt = 0;
        end else begin
            if (tb_drv) check("bus_contention", 128'(cmd_w), 128'(tb_cmd));
            if (!tb_drv && cmd_w == C2_WRITE_LINE) begin
                if (wcnt < BEATS) wline[wcnt*DATA_W +: DATA_W] = data_w;
                wcnt++;
                waddr = int'(addr_w);
            end else if (wcnt > 0) begin
                check("write_beats", 128'(wcnt), 128'(BEATS));
                if (wr_exp_line.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL write_burst: got unexpected burst expected none");
                end else begin
                    check("write_line", wline, wr_exp_line.pop_front());
                    check("write_addr", 128'(waddr), 128'(wr_exp_addr.pop_front()));
                end
                bus_mem[waddr[2:0]] = wline;
                wcnt = 0;
            end
            if (!tb_drv && cmd_w == C2_READ_LINE) begin
                rcnt++;
            end else if (rcnt > 0) begin
                check("read_cmd_cycles", 128'(rcnt), 128'd1);
                rcnt = 0;
            end
        end
    end

    // Memory responder: answers READ_LINE after the delay chosen for that read (negative = silent).
    initial begin : responder
        int d;
        int a;
        logic [127:0] rl;
        forever begin
            @(negedge clk);
            if (reset && !tb_drv && cmd_w == C2_READ_LINE) begin
                d = (dly_q.size() > 0) ? dly_q.pop_front() : 0;
                a = int'(addr_w[2:0]);
                @(posedge clk);
                if (d >= 0) begin
                    repeat (d) @(posedge clk);
                    #1;
                    rl = bus_mem[a];
                    tb_drv = 1'b1;
                    tb_cmd = C2_RESPONSE;
                    tb_dat = '0;
                    for (int k = 0; k < BEATS; k++) begin
                        @(posedge clk);
                        #1;
                        tb_cmd = C2_NOP;
                        tb_dat = rl[k*DATA_W +: DATA_W];
                    end
                    @(posedge clk);
                    #1;
                    tb_drv = 1'b0;
                end
            end
        end
    end

    initial begin : main
        logic [127:0] ln;
        int n0;
        for (int i = 0; i < 8; i++) begin
            ln = {$urandom, $urandom, $urandom, $urandom};
            ref_mem[i] = ln;
            bus_mem[i] = ln;
        end
        ref_mem[0] = 128'h0807_0706_0605_0504_0403_0302_0201_0100;
        bus_mem[0] = ref_mem[0];
        bif.req_valid = 1'b0;
        bif.req_write = 1'b0;
        bif.req_addr  = '0;
        bif.req_wdata = '0;

        // Reset state
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cmd", 128'(cmd_w), 128'(C2_NOP));
        check("rst_data", 128'(data_w), 128'd0);
        check("rst_addr", 128'(addr_w), 128'd0);
        check("rst_req_ready", 128'(bif.req_ready), 128'd1);
        check("rst_resp_valid", 128'(bif.resp_valid), 128'd0);
        check("rst_resp_err", 128'(bif.resp_err), 128'd0);
        check("rst_resp_rdata", bif.resp_rdata, 128'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Reset in the middle of a write burst aborts it silently
        issue(1'b1, 3, 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555, 0, 1'b0);
        bif.req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("midrst_cmd", 128'(cmd_w), 128'(C2_NOP));
        check("midrst_req_ready", 128'(bif.req_ready), 128'd1);
        n0 = resp_edges.size();
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check("midrst_no_resp", 128'(resp_edges.size()), 128'(n0));

        // Directed read with two idle cycles before RESPONSE
        issue(1'b0, 0, '0, 2, 1'b1);
        bif.req_valid = 1'b0;
        wait_done();

        // Directed write of bytes 0x00..0x0F, then read it back
        issue(1'b1, 5, 128'h0F0E_0D0C_0B0A_0908_0706_0504_0302_0100, 0, 1'b1);
        bif.req_valid = 1'b0;
        wait_done();
        issue(1'b0, 5, '0, 1, 1'b1);
        bif.req_valid = 1'b0;
        wait_done();

        // Back-to-back writes with req_valid held high
        n0 = resp_edges.size();
        issue(1'b1, 6, {$urandom, $urandom, $urandom, $urandom}, 0, 1'b1);
        issue(1'b1, 7, {$urandom, $urandom, $urandom, $urandom}, 0, 1'b1);
        bif.req_valid = 1'b0;
        wait_done();
        if (resp_edges.size() > n0) begin
            check("b2b_accept", 128'(last_acc), 128'(resp_edges[n0] + 1));
        end else begin
            total++;
            bad++;
            $display("FAIL b2b_accept: got no first response expected one");
        end

`ifdef C2_TIMEOUT_EN
        // Silent responder: read times out with error, bus returns to master NOP
        issue(1'b0, 2, '0, -1, 1'b1);
        bif.req_valid = 1'b0;
        wait_done();
`endif

        // Random mix of reads and writes, sometimes back-to-back, sometimes with idle gaps
        for (int t = 0; t < 40; t++) begin
            issue(1'($urandom % 2), int'($urandom % 8), {$urandom, $urandom, $urandom, $urandom},
                  int'($urandom % 4), 1'b1);
            if ($urandom % 3 == 0) begin
                bif.req_valid = 1'b0;
                repeat ($urandom % 3) @(posedge clk);
                #1;
            end
        end
        bif.req_valid = 1'b0;
        wait_done();
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("write_bursts_left", 128'(wr_exp_line.size()), 128'd0);
        check("idle_cmd_nop", 128'(cmd_w), 128'(C2_NOP));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
